// File: rtl/pim_mac_array.sv
// LANES lock-step multiply-accumulate lanes with beat/result handshakes.
// Pipeline: operand register, product register, accumulate into result.
module pim_mac_array #(
  parameter int LANES = 4,
  parameter int A_W   = 26,
  parameter int B_W   = 29,
  parameter int ACC_W = 64,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic                   in_signed,
  input  logic [LANES*A_W-1:0]   a_vec,
  input  logic [LANES*B_W-1:0]   b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] psum_vec,
  output logic [LANES-1:0]       ovf,
  output logic [CNT_W-1:0]       out_beats
);
  localparam int P_W = A_W + B_W;
  localparam logic [ACC_W-1:0] HI_MASK = {ACC_W{1'b1}} << P_W;

  logic                        s0_valid, s0_last, s0_signed;
  logic [LANES-1:0][A_W-1:0]   s0_a;
  logic [LANES-1:0][B_W-1:0]   s0_b;
  logic                        s1_valid, s1_last, s1_signed;
  logic [LANES-1:0][P_W-1:0]   s1_prod;
  logic [LANES-1:0][ACC_W-1:0] acc;
  logic [LANES-1:0]            sticky;
  logic [CNT_W-1:0]            cnt;
  logic [LANES-1:0][P_W-1:0]   prod;
  logic [LANES-1:0][ACC_W-1:0] sum;
  logic [LANES-1:0]            beat_ovf;
  logic [CNT_W-1:0]            cnt_inc;
  logic                        accept;

  // Holding off while a last beat is in S0/S1 keeps the result register free
  // by the time that beat is accumulated.
  assign in_ready = !clear && !(s0_valid && s0_last) && !(s1_valid && s1_last)
                    && !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [P_W-1:0]   a_x, b_x;
    logic [ACC_W-1:0] p_ext, sat_val;
    logic [ACC_W:0]   raw;

    // Low P_W bits of the product are identical for signed and unsigned once
    // the operands are extended according to the mode.
    assign a_x     = {{B_W{s0_signed & s0_a[i][A_W-1]}}, s0_a[i]};
    assign b_x     = {{A_W{s0_signed & s0_b[i][B_W-1]}}, s0_b[i]};
    assign prod[i] = a_x * b_x;

    assign p_ext = ACC_W'(s1_prod[i]) |
                   ((s1_signed && s1_prod[i][P_W-1]) ? HI_MASK : '0);
    assign raw   = {s1_signed & acc[i][ACC_W-1], acc[i]} +
                   {s1_signed & p_ext[ACC_W-1], p_ext};

    assign beat_ovf[i] = s1_signed ? (raw[ACC_W] ^ raw[ACC_W-1]) : raw[ACC_W];
    assign sat_val     = !s1_signed       ? {ACC_W{1'b1}} :
                         acc[i][ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                            {1'b0, {(ACC_W-1){1'b1}}};
    assign sum[i]      = (SAT != 0 && beat_ovf[i]) ? sat_val : raw[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s0_signed <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_signed <= 1'b0;
      s1_prod   <= '0;
      acc       <= '0;
      sticky    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      psum_vec  <= '0;
      ovf       <= '0;
      out_beats <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clear) begin
        s0_valid <= 1'b0;
        s1_valid <= 1'b0;
        acc      <= '0;
        sticky   <= '0;
        cnt      <= '0;
      end else begin
        s0_valid <= accept;
        if (accept) begin
          s0_last   <= in_last;
          s0_signed <= in_signed;
          s0_a      <= a_vec;
          s0_b      <= b_vec;
        end
        s1_valid <= s0_valid;
        if (s0_valid) begin
          s1_last   <= s0_last;
          s1_signed <= s0_signed;
          s1_prod   <= prod;
        end
        if (s1_valid) begin
          if (s1_last) begin
            psum_vec  <= sum;
            ovf       <= sticky | beat_ovf;
            out_beats <= cnt_inc;
            out_valid <= 1'b1;
            acc       <= '0;
            sticky    <= '0;
            cnt       <= '0;
          end else begin
            acc    <= sum;
            sticky <= sticky | beat_ovf;
            cnt    <= cnt_inc;
          end
        end
      end
    end
  end
endmodule
